// File: rtl/cr_jpeg_pkg.sv
// Shared definitions for the Cr JPEG coefficient path.
//   COEFF_W / N_COEFF : coefficient width and coefficients per 8x8 block
//   coeff_t           : signed DCT coefficient
//   zz_idx_t          : 6-bit position within a block (zigzag or row-major)
//   state_t           : transmit FSM states
package cr_jpeg_pkg;

   localparam int COEFF_W = 11;
   localparam int N_COEFF = 64;

   typedef logic signed [COEFF_W-1:0] coeff_t;
   typedef logic [5:0]                zz_idx_t;

   typedef enum logic {IDLE, STREAM} state_t;

endpackage

// File: rtl/cr_zigzag_rom.sv
// Zigzag lookup: maps a zigzag scan position (0..63) to the row-major
// index of that coefficient inside an 8x8 block. Purely combinational.
//   pos : zigzag position
//   rm  : row-major index (8*row + col, zero based)
module cr_zigzag_rom
   import cr_jpeg_pkg::*;
(
   input  zz_idx_t pos,
   output zz_idx_t rm
);

   localparam zz_idx_t ZZ [N_COEFF] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   assign rm = ZZ[pos];

endmodule

// File: rtl/cr_coeff_zigzag_tx.sv
// Cr coefficient transmitter: captures an 8x8 block of signed DCT
// coefficients on a single in_valid pulse and streams them out one per
// valid/ready handshake in JPEG zigzag order. One extra block can be held
// pending while the active block drains; a third arriving block is dropped.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : 1-cycle block strobe (DCT output_enable)
//   coeff_in   : row-major packed block, element k at [k*COEFF_W +: COEFF_W]
//   in_ready   : pending slot empty (registered)
//   out_valid  : coeff_out/out_index/out_last valid
//   out_ready  : downstream accepts current coefficient
//   coeff_out  : coefficient in zigzag order
//   out_index  : zigzag position of coeff_out
//   out_last   : high on zigzag position 63
//   overflow   : 1-cycle pulse when a block is dropped
module cr_coeff_zigzag_tx
   import cr_jpeg_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [N_COEFF*COEFF_W-1:0] coeff_in,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output coeff_t                     coeff_out,
   output zz_idx_t                    out_index,
   output logic                       out_last,
   output logic                       overflow
);

   state_t  state, state_nxt;
   coeff_t  active [N_COEFF];
   coeff_t  pend   [N_COEFF];
   coeff_t  blk_in [N_COEFF];
   logic    pend_full, pend_nxt;
   zz_idx_t idx, rm;
   logic    hs, eob;
   logic    ld_act_in, ld_act_pend, ld_pend, idx_clr, idx_inc, ovf;

   for (genvar k = 0; k < N_COEFF; k++) begin : g_unpack
      assign blk_in[k] = coeff_in[k*COEFF_W +: COEFF_W];
   end

   cr_zigzag_rom u_rom (
      .pos (idx),
      .rm  (rm)
   );

   assign hs  = (state == STREAM) & out_ready;
   assign eob = hs & (idx == 6'd63);

   always_comb begin
      state_nxt   = state;
      pend_nxt    = pend_full;
      ld_act_in   = 1'b0;
      ld_act_pend = 1'b0;
      ld_pend     = 1'b0;
      idx_clr     = 1'b0;
      idx_inc     = 1'b0;
      ovf         = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               ld_act_in = 1'b1;
               idx_clr   = 1'b1;
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (eob) begin
               // Last beat leaves: refill active from pending first, else
               // directly from a coincident strobe, so there is no bubble.
               idx_clr = 1'b1;
               if (pend_full) begin
                  ld_act_pend = 1'b1;
                  if (in_valid) ld_pend  = 1'b1;
                  else          pend_nxt = 1'b0;
               end else if (in_valid) begin
                  ld_act_in = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               idx_inc = hs;
               if (in_valid) begin
                  if (!pend_full) begin
                     ld_pend  = 1'b1;
                     pend_nxt = 1'b1;
                  end else begin
                     ovf = 1'b1;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         pend_full <= 1'b0;
         in_ready  <= 1'b1;
         overflow  <= 1'b0;
         for (int k = 0; k < N_COEFF; k++) begin
            active[k] <= '0;
            pend[k]   <= '0;
         end
      end else begin
         state     <= state_nxt;
         pend_full <= pend_nxt;
         in_ready  <= ~pend_nxt;
         overflow  <= ovf;
         // idx is also cleared on the return to IDLE so out_index reads 0
         if (idx_clr)      idx <= '0;
         else if (idx_inc) idx <= idx + 6'd1;
         for (int k = 0; k < N_COEFF; k++) begin
            if (ld_act_in)        active[k] <= blk_in[k];
            else if (ld_act_pend) active[k] <= pend[k];
            if (ld_pend)          pend[k]   <= blk_in[k];
         end
      end
   end

   assign out_valid = (state == STREAM);
   assign coeff_out = out_valid ? active[rm] : '0;
   assign out_index = idx;
   assign out_last  = out_valid & (idx == 6'd63);

endmodule

// File: tb/tb_cr_coeff_zigzag_tx.sv
module tb_cr_coeff_zigzag_tx;
   import cr_jpeg_pkg::*;

   logic                       clk = 1'b0;
   logic                       rst = 1'b1;
   logic                       in_valid = 1'b0;
   logic                       out_ready = 1'b0;
   logic [N_COEFF*COEFF_W-1:0] coeff_in = '0;
   logic                       in_ready, out_valid, out_last, overflow;
   coeff_t                     coeff_out;
   zz_idx_t                    out_index;

   cr_coeff_zigzag_tx dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .coeff_in  (coeff_in),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .coeff_out (coeff_out),
      .out_index (out_index),
      .out_last  (out_last),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int v;
      int idx;
      int last;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   beats    = 0;

   // standard JPEG zigzag, hand-entered
   int zz [64] = '{
      0, 1, 8,16, 9, 2, 3,10,17,24,32,25,18,11, 4, 5,
     12,19,26,33,40,48,41,34,27,20,13, 6, 7,14,21,28,
     35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,
     58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // kind 0: element k = base+k ; kind 1: element k = -(k+1)
   function automatic int val(input int kind, input int base, input int k);
      return (kind == 0) ? base + k : -(k + 1);
   endfunction

   task automatic send_block(input int kind, input int base, input bit keep,
                             output int cap_cyc);
      exp_t e;
      @(posedge clk); #1;
      for (int k = 0; k < 64; k++)
         coeff_in[k*COEFF_W +: COEFF_W] = coeff_t'(val(kind, base, k));
      in_valid = 1'b1;
      if (keep) begin
         for (int p = 0; p < 64; p++) begin
            e.v    = val(kind, base, zz[p]);
            e.idx  = p;
            e.last = (p == 63) ? 1 : 0;
            q.push_back(e);
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      cap_cyc  = cyc;
   endtask

   // bp=1 drives out_ready with the repeating pattern 1,0,0,1
   task automatic wait_drain(input int budget, input bit bp, output int end_cyc);
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         if (bp) out_ready = ((n % 4) == 0) || ((n % 4) == 3);
         n++;
      end
      chk("drain_timeout_left", q.size(), 0);
      end_cyc = cyc;
   endtask

   // monitor / scoreboard
   exp_t    m_e;
   bit      stl = 1'b0;
   coeff_t  sv_c;
   zz_idx_t sv_i;

   always @(negedge clk) begin
      if (rst) begin
         stl = 1'b0;
      end else begin
         if (stl) begin
            chk("hold_coeff", coeff_out, sv_c);
            chk("hold_index", out_index, sv_i);
         end
         stl  = out_valid && !out_ready;
         sv_c = coeff_out;
         sv_i = out_index;
         if (q.size() == 0) begin
            chk("idle_out_valid", out_valid, 0);
         end else if (out_valid && out_ready) begin
            m_e = q.pop_front();
            chk("beat_coeff", coeff_out, m_e.v);
            chk("beat_index", out_index, m_e.idx);
            chk("beat_last", out_last, m_e.last);
            beats++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int c0, c1, cb, b0, n;

      // reset values
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_coeff_out", coeff_out, 0);
      chk("rst_out_index", out_index, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_overflow", overflow, 0);
      @(posedge clk); #2;
      rst = 1'b0;

      // single block, ramp values
      out_ready = 1'b1;
      send_block(0, 0, 1, c0);
      chk("single_first_valid", out_valid, 1);
      wait_drain(200, 0, c1);
      chk("single_len", c1 - c0, 64);
      @(negedge clk);
      chk("single_done_valid", out_valid, 0);

      // negative values under backpressure
      b0 = beats;
      send_block(1, 0, 1, c0);
      wait_drain(400, 1, c1);
      chk("bp_beats", beats - b0, 64);
      out_ready = 1'b1;

      // back-to-back: B strobed during A's beat 10
      send_block(0, 0, 1, c0);
      repeat (9) @(posedge clk);
      send_block(0, 100, 1, cb);
      chk("b2b_in_ready_low", in_ready, 0);
      wait_drain(300, 0, c1);
      chk("b2b_len", c1 - c0, 128);
      chk("b2b_in_ready_high", in_ready, 1);

      // overflow: A active, B pending, C dropped
      out_ready = 1'b0;
      send_block(0, 0, 1, c0);
      send_block(0, 200, 1, cb);
      chk("ovf_after_b", overflow, 0);
      chk("ovf_in_ready_b", in_ready, 0);
      send_block(0, 500, 0, cb);
      chk("ovf_pulse", overflow, 1);
      chk("ovf_in_ready_c", in_ready, 0);
      @(posedge clk); #1;
      chk("ovf_pulse_end", overflow, 0);
      out_ready = 1'b1;
      wait_drain(300, 0, c1);
      chk("ovf_in_ready_end", in_ready, 1);

      // strobe coincident with A's idx-63 handshake, pending empty
      send_block(0, 0, 1, c0);
      repeat (62) @(posedge clk);
      send_block(0, 300, 1, cb);
      chk("eob_out_valid", out_valid, 1);
      chk("eob_out_index", out_index, 0);
      chk("eob_coeff", coeff_out, 300);
      chk("eob_overflow", overflow, 0);
      chk("eob_in_ready", in_ready, 1);
      wait_drain(300, 0, c1);
      chk("eob_len", c1 - c0, 128);

      // asynchronous reset mid-stream
      b0 = beats;
      send_block(0, 0, 1, c0);
      n = 0;
      while (beats < b0 + 30 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reach_beat30", beats - b0, 30);
      #2;
      rst = 1'b1;
      q.delete();
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_coeff", coeff_out, 0);
      chk("mid_rst_index", out_index, 0);
      chk("mid_rst_last", out_last, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      @(posedge clk); #2;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("post_rst_idle", out_valid, 0);

      // recovery after reset
      send_block(0, 7, 1, c0);
      wait_drain(200, 0, c1);
      chk("recover_len", c1 - c0, 64);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
